// File: rtl/vram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_bus_arbiter
// Description : Shares one 8-bit VRAM bus between the video scanout engines and
//               the CPU port. While the raster is visible, bus slots alternate
//               video (phase 0) / CPU (phase 1). During blanking, video requests
//               win and the CPU takes any remaining cycle. Every memory-side
//               output and every result output is registered.
// Ports       : clk_in, rst_in (async, active-high), vis_in
//               video_req/video_addr -> video_data/video_valid
//               cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack
//               mem_addr/mem_wdata/mem_we/mem_oe -> VRAM, mem_rdata <- VRAM
// Revision    : 1.0 - initial release
// ============================================================================
module vram_bus_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              vis_in,
    input  logic              video_req,
    input  logic [ADDR_W-1:0] video_addr,
    output logic [DATA_W-1:0] video_data,
    output logic              video_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Owner of the access currently on the bus; selects where the returning
    // byte goes on the following edge.
    localparam logic [1:0] c_TAG_NONE = 2'd0;
    localparam logic [1:0] c_TAG_VID  = 2'd1;
    localparam logic [1:0] c_TAG_CPU  = 2'd2;

    logic              r_phase;
    logic              r_cpu_busy;
    logic [1:0]        r_tag;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_oe;
    logic [DATA_W-1:0] r_video_data;
    logic              r_video_valid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ack;

    logic w_cpu_ok;
    logic w_grant_vid;
    logic w_grant_cpu;

    // The two grants are mutually exclusive: visible slots give each side its
    // own phase, and in blanking the CPU only wins when video is not asking.
    assign w_cpu_ok    = cpu_req & ~r_cpu_busy;
    assign w_grant_vid = video_req & (~vis_in | ~r_phase);
    assign w_grant_cpu = w_cpu_ok & (vis_in ? r_phase : ~video_req);

    // Slot phase: held at 0 in blanking so the first visible cycle is video.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= vis_in & ~r_phase;
        end
    end

    // Bus launch: one access per granted edge, strobes dropped when idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_oe    <= 1'b0;
            r_tag       <= c_TAG_NONE;
        end else if (w_grant_vid) begin
            r_mem_addr <= video_addr;
            r_mem_oe   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_tag      <= c_TAG_VID;
        end else if (w_grant_cpu) begin
            r_mem_addr <= cpu_addr;
            r_mem_oe   <= ~cpu_we;
            r_mem_we   <= cpu_we;
            if (cpu_we) begin
                r_mem_wdata <= cpu_wdata;
            end
            r_tag      <= c_TAG_CPU;
        end else begin
            r_mem_we <= 1'b0;
            r_mem_oe <= 1'b0;
            r_tag    <= c_TAG_NONE;
        end
    end

    // Busy stays set through the ack cycle and clears one edge later, so a
    // cpu_req still held while the CPU reacts to the ack is not served twice.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cpu_busy <= 1'b0;
        end else if (r_cpu_ack) begin
            r_cpu_busy <= 1'b0;
        end else if (w_grant_cpu) begin
            r_cpu_busy <= 1'b1;
        end
    end

    // Completion: VRAM returns data during the cycle after the address, so the
    // tag from the previous edge routes mem_rdata to its owner.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_video_data  <= '0;
            r_video_valid <= 1'b0;
            r_cpu_rdata   <= '0;
            r_cpu_ack     <= 1'b0;
        end else begin
            r_video_valid <= (r_tag == c_TAG_VID);
            r_cpu_ack     <= (r_tag == c_TAG_CPU);
            if (r_tag == c_TAG_VID) begin
                r_video_data <= mem_rdata;
            end
            // r_mem_we still describes the access launched on the last edge.
            if ((r_tag == c_TAG_CPU) && !r_mem_we) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign mem_oe      = r_mem_oe;
    assign video_data  = r_video_data;
    assign video_valid = r_video_valid;
    assign cpu_rdata   = r_cpu_rdata;
    assign cpu_ack     = r_cpu_ack;

endmodule
`default_nettype wire
